mold_retrans_req_tx: RTL and testbench

// Transmit side of MoldUDP64 recovery: turns one missed-message range (sid, start seq, count) into
// one or more 20-byte MoldUDP64 retransmission request packets on a 64-bit AXI-stream toward the UDP TX.

---
 rtl/mold_pkg.sv | 12 +
 rtl/mold_req_pack.sv | 39 +++
 rtl/mold_retrans_req_tx.sv | 101 ++++++++++
 tb/tb_mold_retrans_req_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mold_pkg.sv
// Shared MoldUDP64 retransmission-request constants and the request FSM state type.
package mold_pkg;
  localparam int SID_W        = 80;
  localparam int SEQ_NUM_W    = 64;
  localparam int ML_W         = 16;
  localparam int AXI_DATA_W   = 64;
  localparam int AXI_KEEP_W   = 8;
  localparam int MOLD_REQ_LEN = 20;
  localparam logic [ML_W-1:0] REQ_CNT_MAX_DEF = 16'hFFFE;

  typedef enum logic [1:0] {IDLE, B0, B1, B2} mold_req_fsm_e;
endpackage

// File: rtl/mold_req_pack.sv
// Maps beat index + request fields onto the 64-bit lanes, packet byte k on lane k (network order).
// Purely combinational; no latency, no flow control.
module mold_req_pack
  import mold_pkg::*;
(
  input  mold_req_fsm_e           beat,
  input  logic [SID_W-1:0]        sid,
  input  logic [SEQ_NUM_W-1:0]    seq,
  input  logic [ML_W-1:0]         chunk,
  output logic [AXI_DATA_W-1:0]   data,
  output logic [AXI_KEEP_W-1:0]   keep,
  output logic                    last
);
  // Packet byte 0 sits in the most significant byte of pkt.
  logic [8*MOLD_REQ_LEN-1:0] pkt;
  assign pkt = {sid, seq, chunk};

  always_comb begin
    data = '0;
    keep = '0;
    last = 1'b0;
    case (beat)
      B0: begin
        for (int k = 0; k < 8; k++) data[8*k +: 8] = pkt[8*(MOLD_REQ_LEN-1-k) +: 8];
        keep = 8'hFF;
      end
      B1: begin
        for (int k = 0; k < 8; k++) data[8*k +: 8] = pkt[8*(MOLD_REQ_LEN-9-k) +: 8];
        keep = 8'hFF;
      end
      B2: begin
        for (int k = 0; k < 4; k++) data[8*k +: 8] = pkt[8*(MOLD_REQ_LEN-17-k) +: 8];
        keep = 8'h0F;
        last = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mold_retrans_req_tx.sv
// Turns a missed range into 20-byte MoldUDP64 request packets, split at REQ_CNT_MAX messages each.
// First beat 1 cycle after accept; beats held while stalled; new range accepted only when idle.
module mold_retrans_req_tx
  import mold_pkg::*;
#(
  parameter logic [ML_W-1:0] REQ_CNT_MAX = REQ_CNT_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  miss_v_i,
  output logic                  miss_ready_o,
  input  logic [SID_W-1:0]      miss_sid_i,
  input  logic [SEQ_NUM_W-1:0]  miss_seq_start_i,
  input  logic [SEQ_NUM_W-1:0]  miss_seq_cnt_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [AXI_DATA_W-1:0] req_data_o,
  output logic [AXI_KEEP_W-1:0] req_keep_o,
  output logic                  req_last_o,
  output logic [31:0]           req_sent_cnt_o
);
  mold_req_fsm_e        state, nxt_state;
  logic [SID_W-1:0]     sid_q, nxt_sid;
  logic [SEQ_NUM_W-1:0] seq_q, nxt_seq;
  logic [SEQ_NUM_W-1:0] rem_q, nxt_rem;
  logic [31:0]          nxt_sent;
  logic [ML_W-1:0]      cur_chunk, nxt_chunk;
  logic [AXI_DATA_W-1:0] pk_data;
  logic [AXI_KEEP_W-1:0] pk_keep;
  logic                  pk_last;

  assign cur_chunk = (rem_q > SEQ_NUM_W'(REQ_CNT_MAX)) ? REQ_CNT_MAX : rem_q[ML_W-1:0];
  assign nxt_chunk = (nxt_rem > SEQ_NUM_W'(REQ_CNT_MAX)) ? REQ_CNT_MAX : nxt_rem[ML_W-1:0];

  always_comb begin
    nxt_state = state;
    nxt_sid   = sid_q;
    nxt_seq   = seq_q;
    nxt_rem   = rem_q;
    nxt_sent  = req_sent_cnt_o;
    case (state)
      IDLE: begin
        if (miss_v_i) begin
          nxt_sid = miss_sid_i;
          nxt_seq = miss_seq_start_i;
          nxt_rem = miss_seq_cnt_i;
          // A zero-length range is consumed without emitting anything.
          if (miss_seq_cnt_i != '0) nxt_state = B0;
        end
      end
      B0: if (req_ready_i) nxt_state = B1;
      B1: if (req_ready_i) nxt_state = B2;
      B2: begin
        if (req_ready_i) begin
          nxt_sent  = req_sent_cnt_o + 32'd1;
          nxt_seq   = seq_q + SEQ_NUM_W'(cur_chunk);
          nxt_rem   = rem_q - SEQ_NUM_W'(cur_chunk);
          nxt_state = (nxt_rem != '0) ? B0 : IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Beat contents are computed from next-state values so every output is a flop.
  mold_req_pack u_pack (
    .beat  (nxt_state),
    .sid   (nxt_sid),
    .seq   (nxt_seq),
    .chunk (nxt_chunk),
    .data  (pk_data),
    .keep  (pk_keep),
    .last  (pk_last)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state          <= IDLE;
      sid_q          <= '0;
      seq_q          <= '0;
      rem_q          <= '0;
      miss_ready_o   <= 1'b1;
      req_valid_o    <= 1'b0;
      req_data_o     <= '0;
      req_keep_o     <= '0;
      req_last_o     <= 1'b0;
      req_sent_cnt_o <= '0;
    end else begin
      state          <= nxt_state;
      sid_q          <= nxt_sid;
      seq_q          <= nxt_seq;
      rem_q          <= nxt_rem;
      miss_ready_o   <= (nxt_state == IDLE);
      req_valid_o    <= (nxt_state != IDLE);
      req_data_o     <= pk_data;
      req_keep_o     <= pk_keep;
      req_last_o     <= pk_last;
      req_sent_cnt_o <= nxt_sent;
    end
  end
endmodule

// File: tb/tb_mold_retrans_req_tx.sv
// Directed bench: three instances (default max, max=4, max=2) share data inputs, each has its own valid.
module tb_mold_retrans_req_tx;
  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        mv [3];
  logic        mr [3];
  logic [79:0] sid = '0;
  logic [63:0] start = '0;
  logic [63:0] cnt = '0;
  logic        req_ready = 1'b1;
  logic        rv [3];
  logic [63:0] rd [3];
  logic [7:0]  rk [3];
  logic        rl [3];
  logic [31:0] rs [3];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mold_retrans_req_tx u0 (
    .clk(clk), .nreset(nreset), .miss_v_i(mv[0]), .miss_ready_o(mr[0]),
    .miss_sid_i(sid), .miss_seq_start_i(start), .miss_seq_cnt_i(cnt),
    .req_valid_o(rv[0]), .req_ready_i(req_ready), .req_data_o(rd[0]),
    .req_keep_o(rk[0]), .req_last_o(rl[0]), .req_sent_cnt_o(rs[0]));

  mold_retrans_req_tx #(.REQ_CNT_MAX(16'd4)) u1 (
    .clk(clk), .nreset(nreset), .miss_v_i(mv[1]), .miss_ready_o(mr[1]),
    .miss_sid_i(sid), .miss_seq_start_i(start), .miss_seq_cnt_i(cnt),
    .req_valid_o(rv[1]), .req_ready_i(req_ready), .req_data_o(rd[1]),
    .req_keep_o(rk[1]), .req_last_o(rl[1]), .req_sent_cnt_o(rs[1]));

  mold_retrans_req_tx #(.REQ_CNT_MAX(16'd2)) u2 (
    .clk(clk), .nreset(nreset), .miss_v_i(mv[2]), .miss_ready_o(mr[2]),
    .miss_sid_i(sid), .miss_seq_start_i(start), .miss_seq_cnt_i(cnt),
    .req_valid_o(rv[2]), .req_ready_i(req_ready), .req_data_o(rd[2]),
    .req_keep_o(rk[2]), .req_last_o(rl[2]), .req_sent_cnt_o(rs[2]));

  // Byte-level reference: packet bytes in network order, byte 8*b+k on lane k of beat b.
  function automatic logic [63:0] exp_beat(input logic [79:0] s, input logic [63:0] q,
                                           input logic [15:0] c, input int b);
    logic [7:0]  by [20];
    logic [63:0] d;
    d = '0;
    for (int i = 0; i < 10; i++) by[i] = s[79-8*i -: 8];
    for (int i = 0; i < 8; i++) by[10+i] = q[63-8*i -: 8];
    by[18] = c[15:8];
    by[19] = c[7:0];
    for (int k = 0; k < 8; k++) if (8*b+k < 20) d[8*k +: 8] = by[8*b+k];
    return d;
  endfunction

  // Presents a range to instance k and returns just after the accepting edge.
  task automatic send(input int k, input logic [79:0] s, input logic [63:0] st, input logic [63:0] c);
    bit acc;
    acc = 1'b0;
    sid = s; start = st; cnt = c;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      mv[k] = 1'b1;
      if (mr[k]) acc = 1'b1;
    end
    n_chk++; if (!acc) $display("FAIL send_accept inst=%0d ready never seen", k); else n_pass++;
    @(posedge clk); #1;
    mv[k] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_chk++; if ({rv[k], rl[k], rk[k], rd[k], rs[k]} !== '0) $display("FAIL reset_outputs inst=%0d got v=%b l=%b k=%h d=%h s=%0d want all 0", k, rv[k], rl[k], rk[k], rd[k], rs[k]); else n_pass++;
    end
    nreset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (mr[k] !== 1'b1 || rv[k] !== 1'b0) $display("FAIL reset_release inst=%0d got ready=%b valid=%b want 1 0", k, mr[k], rv[k]); else n_pass++;
    end
  endtask

  task automatic test_single();
    req_ready = 1'b1;
    send(0, 80'h1, 64'd100, 64'd5);
    @(negedge clk);
    n_chk++; if (rv[0] !== 1'b1 || mr[0] !== 1'b0) $display("FAIL single_latency got valid=%b ready=%b want 1 0", rv[0], mr[0]); else n_pass++;
    n_chk++; if (rd[0] !== 64'h0 || rk[0] !== 8'hFF || rl[0] !== 1'b0) $display("FAIL single_b0 got d=%h k=%h l=%b want 0 ff 0", rd[0], rk[0], rl[0]); else n_pass++;
    @(negedge clk);
    n_chk++; if (rd[0] !== 64'h0000_0000_0000_0100 || rk[0] !== 8'hFF || rl[0] !== 1'b0) $display("FAIL single_b1 got d=%h k=%h l=%b want 100 ff 0", rd[0], rk[0], rl[0]); else n_pass++;
    @(negedge clk);
    n_chk++; if (rd[0] !== 64'h0000_0000_0500_6400 || rk[0] !== 8'h0F || rl[0] !== 1'b1) $display("FAIL single_b2 got d=%h k=%h l=%b want 05006400 0f 1", rd[0], rk[0], rl[0]); else n_pass++;
    @(negedge clk);
    n_chk++; if (rv[0] !== 1'b0 || mr[0] !== 1'b1 || rs[0] !== 32'd1) $display("FAIL single_done got v=%b rdy=%b sent=%0d want 0 1 1", rv[0], mr[0], rs[0]); else n_pass++;
  endtask

  task automatic test_endianness();
    send(0, 80'h0102_0304_0506_0708_090A, 64'h1112_1314_1516_1718, 64'd3);
    @(negedge clk);
    n_chk++; if (rd[0] !== 64'h0807_0605_0403_0201) $display("FAIL endian_b0 got %h want 0807060504030201", rd[0]); else n_pass++;
    @(negedge clk);
    n_chk++; if (rd[0] !== 64'h1615_1413_1211_0A09) $display("FAIL endian_b1 got %h want 161514131211 0a09", rd[0]); else n_pass++;
    @(negedge clk);
    n_chk++; if (rd[0] !== 64'h0000_0000_0300_1817 || rk[0] !== 8'h0F) $display("FAIL endian_b2 got d=%h k=%h want 03001817 0f", rd[0], rk[0]); else n_pass++;
    @(negedge clk);
    n_chk++; if (rs[0] !== 32'd2) $display("FAIL endian_sent got %0d want 2", rs[0]); else n_pass++;
  endtask

  task automatic test_zero();
    bit bad;
    bad = 1'b0;
    send(0, 80'h55, 64'd7, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rv[0] !== 1'b0 || mr[0] !== 1'b1) bad = 1'b1;
    end
    n_chk++; if (bad) $display("FAIL zero_cnt got a beat or ready dropped, want idle"); else n_pass++;
    n_chk++; if (rs[0] !== 32'd2) $display("FAIL zero_sent got %0d want 2", rs[0]); else n_pass++;
  endtask

  task automatic test_split();
    logic [63:0] exp_b2 [3];
    bit gap;
    exp_b2[0] = 64'h0400_0A00;
    exp_b2[1] = 64'h0400_0E00;
    exp_b2[2] = 64'h0200_1200;
    gap = 1'b0;
    send(1, 80'h5, 64'd10, 64'd10);
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 3; b++) begin
        @(negedge clk);
        if (rv[1] !== 1'b1 || mr[1] !== 1'b0) gap = 1'b1;
        if (b == 2) begin
          n_chk++; if (rd[1] !== exp_b2[p] || rl[1] !== 1'b1) $display("FAIL split_pkt%0d got d=%h l=%b want %h 1", p, rd[1], rl[1], exp_b2[p]); else n_pass++;
        end
      end
    end
    n_chk++; if (gap) $display("FAIL split_gap got idle or ready during split want continuous"); else n_pass++;
    @(negedge clk);
    n_chk++; if (rv[1] !== 1'b0 || mr[1] !== 1'b1 || rs[1] !== 32'd3) $display("FAIL split_done got v=%b rdy=%b sent=%0d want 0 1 3", rv[1], mr[1], rs[1]); else n_pass++;
  endtask

  task automatic test_wrap();
    send(2, 80'h0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd4);
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (rd[2] !== 64'hFFFF_FFFF_FFFF_0000) $display("FAIL wrap_p0_b1 got %h want ffffffffffff0000", rd[2]); else n_pass++;
    @(negedge clk);
    n_chk++; if (rd[2] !== 64'h0200_FEFF) $display("FAIL wrap_p0_b2 got %h want 0200feff", rd[2]); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (rd[2] !== 64'h0) $display("FAIL wrap_p1_b1 got %h want 0", rd[2]); else n_pass++;
    @(negedge clk);
    n_chk++; if (rd[2] !== 64'h0200_0000 || rl[2] !== 1'b1) $display("FAIL wrap_p1_b2 got d=%h l=%b want 02000000 1", rd[2], rl[2]); else n_pass++;
    @(negedge clk);
    n_chk++; if (rv[2] !== 1'b0 || rs[2] !== 32'd2) $display("FAIL wrap_done got v=%b sent=%0d want 0 2", rv[2], rs[2]); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [79:0] s;
    logic [63:0] q0;
    logic [63:0] prev_d;
    logic [63:0] ed;
    bit          stalled;
    int          e;
    int          bad_stab;
    int          bad_beat;
    s = 80'hDEAD_BEEF_0011_2233_4455;
    q0 = 64'h0123_4567_89AB_CDEF;
    stalled = 1'b0; e = 0; bad_stab = 0; bad_beat = 0; prev_d = '0;
    req_ready = 1'b1;
    send(1, s, q0, 64'd9);
    for (int i = 0; i < 600 && e < 9; i++) begin
      @(negedge clk);
      if (stalled && (rv[1] !== 1'b1 || rd[1] !== prev_d)) bad_stab++;
      req_ready = 1'($urandom_range(0, 1));
      if (rv[1] && req_ready) begin
        ed = exp_beat(s, q0 + 64'(4 * (e / 3)), (e / 3 < 2) ? 16'd4 : 16'd1, e % 3);
        if (rd[1] !== ed || rk[1] !== ((e % 3 == 2) ? 8'h0F : 8'hFF) || rl[1] !== (e % 3 == 2)) begin
          bad_beat++;
          $display("FAIL bp_beat%0d got d=%h k=%h l=%b want d=%h", e, rd[1], rk[1], rl[1], ed);
        end
        e++;
      end
      stalled = rv[1] && !req_ready;
      prev_d = rd[1];
    end
    n_chk++; if (e !== 9) $display("FAIL bp_count got %0d beats want 9", e); else n_pass++;
    n_chk++; if (bad_beat != 0) $display("FAIL bp_data got %0d bad beats want 0", bad_beat); else n_pass++;
    n_chk++; if (bad_stab != 0) $display("FAIL bp_stable got %0d unstable stalls want 0", bad_stab); else n_pass++;
    req_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (rv[1] !== 1'b0 || rs[1] !== 32'd6) $display("FAIL bp_done got v=%b sent=%0d want 0 6", rv[1], rs[1]); else n_pass++;
  endtask

  task automatic test_async_reset();
    req_ready = 1'b1;
    send(0, 80'h7, 64'd0, 64'd5);
    @(negedge clk);
    @(posedge clk); #2;
    n_chk++; if (rv[0] !== 1'b1 || rd[0] !== 64'h0700) $display("FAIL arst_in_b1 got v=%b d=%h want 1 0700", rv[0], rd[0]); else n_pass++;
    nreset = 1'b0;
    #1;
    n_chk++; if (rv[0] !== 1'b0 || rs[0] !== 32'd0 || rl[0] !== 1'b0) $display("FAIL arst_drop got v=%b sent=%0d l=%b want 0 0 0", rv[0], rs[0], rl[0]); else n_pass++;
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    n_chk++; if (mr[0] !== 1'b1 || rv[0] !== 1'b0) $display("FAIL arst_release got rdy=%b v=%b want 1 0", mr[0], rv[0]); else n_pass++;
    send(0, 80'h1, 64'd100, 64'd5);
    repeat (3) @(negedge clk);
    n_chk++; if (rd[0] !== 64'h0500_6400 || rl[0] !== 1'b1) $display("FAIL arst_resend_b2 got d=%h l=%b want 05006400 1", rd[0], rl[0]); else n_pass++;
    @(negedge clk);
    n_chk++; if (rs[0] !== 32'd1 || mr[0] !== 1'b1) $display("FAIL arst_resend_sent got sent=%0d rdy=%b want 1 1", rs[0], mr[0]); else n_pass++;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) mv[k] = 1'b0;
    test_reset();
    test_single();
    test_endianness();
    test_zero();
    test_split();
    test_wrap();
    test_backpressure();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
